// File: rtl/sqrt_vec_pipe.sv
// sqrt_vec_pipe
//   Multi-lane, fully pipelined IEEE-754 binary16 square root with
//   round-to-nearest-even and full subnormal support. The pipeline has three
//   parts. An input register decodes special cases and normalizes the
//   operand. STAGES recurrence stages each resolve 12/STAGES root bits. An
//   output register rounds the root and packs the result. Every register
//   advances together. The whole pipe freezes only while the output holds a
//   result the consumer has not taken.
//
// Ports
//   CLK        rising-edge clock
//   nRST       asynchronous active-low reset
//   in_valid   operand transaction valid
//   in_ready   pipe can accept (low only while the output is stalled)
//   in_data    LANES fp16 operands, lane i at [16i+15:16i]
//   in_mask    per-lane enable; a disabled lane yields 0x0000, no flags
//   in_tag     opaque tag carried with the transaction
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_data   LANES fp16 results
//   out_tag    tag of the transaction on out_data
//   out_nv     per-lane invalid-operation flag
//   out_nx     per-lane inexact flag
//
// STAGES must divide 12 (1, 2, 3, 4, 6 or 12).

module sqrt_vec_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 4,
  parameter int TAG_W  = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*LANES-1:0]    in_data,
  input  logic [LANES-1:0]       in_mask,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*LANES-1:0]    out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic [LANES-1:0]       out_nv,
  output logic [LANES-1:0]       out_nx
);

  localparam int BITS = 12 / STAGES;

  // Per-lane state carried down the pipe. For special lanes, only specData
  // and specNv matter. For normal lanes, rad holds the radicand bits still
  // to be consumed (top pair first). rem and root hold the partial
  // remainder and the partial root. expo holds the biased result exponent.
  typedef struct packed {
    logic        spec;
    logic [15:0] specData;
    logic        specNv;
    logic [4:0]  expo;
    logic [23:0] rad;
    logic [15:0] rem;
    logic [11:0] root;
  } lane_t;

  lane_t                stage_q [STAGES+1][LANES];
  lane_t                stage_d [STAGES+1][LANES];
  logic [TAG_W-1:0]     tag_q   [STAGES+1];
  logic [TAG_W-1:0]     tag_d   [STAGES+1];
  logic [STAGES:0]      vld_q, vld_d;

  logic                 outValid_q, outValid_d;
  logic [16*LANES-1:0]  outData_q, outData_d;
  logic [TAG_W-1:0]     outTag_q, outTag_d;
  logic [LANES-1:0]     outNv_q, outNv_d;
  logic [LANES-1:0]     outNx_q, outNx_d;

  logic                 advance;

  // Left shift that brings a subnormal's leading one up to the hidden-bit
  // position (bit 10).
  function automatic logic [3:0] normShift(input logic [9:0] f);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (f[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

  // Classify one operand and set up the radicand.
  // eb is the unbiased exponent offset by +24, which keeps it non-negative.
  // Its parity then equals the parity of the true exponent, and the result
  // exponent is eb/2 + 3.
  // The radicand is the significand scaled by 2^12, or by 2^13 when the
  // exponent is odd. This gives a 12-bit integer root: 11 result bits plus
  // a guard bit.
  function automatic lane_t decodeLane(input logic [15:0] x, input logic act);
    lane_t      r;
    logic [4:0] e;
    logic [9:0] f;
    logic [3:0] sh;
    logic [10:0] sig;
    logic [5:0] eb;
    r          = '0;
    r.spec     = 1'b1;
    e          = x[14:10];
    f          = x[9:0];
    sh         = normShift(f);
    sig        = '0;
    eb         = '0;
    if (!act) begin
      r.specData = 16'h0000;
    end else if (e == 5'h1f) begin
      r.specData = (f == 10'd0 && !x[15]) ? 16'h7C00 : 16'h7E00;
      r.specNv   = (f != 10'd0) ? !f[9] : x[15];
    end else if (e == 5'd0 && f == 10'd0) begin
      r.specData = x;
    end else if (x[15]) begin
      r.specData = 16'h7E00;
      r.specNv   = 1'b1;
    end else begin
      r.spec = 1'b0;
      if (e != 5'd0) begin
        sig = {1'b1, f};
        eb  = {1'b0, e} + 6'd9;
      end else begin
        sig = 11'({1'b0, f} << sh);
        eb  = 6'd10 - {2'b00, sh};
      end
      r.expo = eb[5:1] + 5'd3;
      r.rad  = eb[0] ? {sig, 13'd0} : {1'b0, sig, 12'd0};
    end
    return r;
  endfunction

  // One restoring square-root step. It pulls in the next two radicand bits
  // and tries to append a 1 to the root.
  function automatic lane_t sqrtStep(input lane_t s);
    lane_t       r;
    logic [15:0] cur;
    logic [15:0] trial;
    r     = s;
    cur   = {s.rem[13:0], s.rad[23:22]};
    trial = {2'b00, s.root, 2'b01};
    r.rad = {s.rad[21:0], 2'b00};
    if (cur >= trial) begin
      r.rem  = cur - trial;
      r.root = {s.root[10:0], 1'b1};
    end else begin
      r.rem  = cur;
      r.root = {s.root[10:0], 1'b0};
    end
    return r;
  endfunction

  function automatic lane_t stageSteps(input lane_t s);
    lane_t r;
    r = s;
    for (int b = 0; b < BITS; b++) r = sqrtStep(r);
    return r;
  endfunction

  // Round to nearest even. root[0] is the guard bit; a nonzero remainder is
  // the sticky bit. The hidden bit is root[11], so a carry out of the
  // 10-bit fraction bumps the exponent.
  function automatic logic [17:0] roundLane(input lane_t s);
    logic        sticky;
    logic        inc;
    logic [10:0] sum;
    logic [4:0]  ex;
    sticky = (s.rem != 16'd0);
    inc    = s.root[0] && (sticky || s.root[1]);
    sum    = {1'b0, s.root[10:1]} + {10'd0, inc};
    ex     = s.expo + {4'd0, sum[10]};
    if (s.spec) return {s.specData, s.specNv, 1'b0};
    return {1'b0, ex, sum[9:0], 1'b0, s.root[0] || sticky};
  endfunction

  // The pipe moves only when the output register is empty or being drained.
  assign advance  = !(outValid_q && !out_ready);
  assign in_ready = advance;

  // Next state for the input register and for each recurrence stage.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      stage_d[0][l] = decodeLane(in_data[16*l +: 16], in_mask[l]);
    end
    for (int k = 1; k <= STAGES; k++) begin
      for (int l = 0; l < LANES; l++) begin
        stage_d[k][l] = stageSteps(stage_q[k-1][l]);
      end
    end
    tag_d[0] = in_tag;
    for (int k = 1; k <= STAGES; k++) tag_d[k] = tag_q[k-1];
    vld_d = {vld_q[STAGES-1:0], in_valid};
  end

  // Output register next state: round the finished root, or pass the
  // special result through.
  always_comb begin
    outData_d  = '0;
    outNv_d    = '0;
    outNx_d    = '0;
    outValid_d = vld_q[STAGES];
    outTag_d   = tag_q[STAGES];
    for (int l = 0; l < LANES; l++) begin
      {outData_d[16*l +: 16], outNv_d[l], outNx_d[l]} = roundLane(stage_q[STAGES][l]);
    end
  end

  // All pipeline registers share one enable, so bubbles keep their slots.
  // Reset clears everything, which discards any transaction in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stage_q    <= '{default: '0};
      tag_q      <= '{default: '0};
      vld_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outTag_q   <= '0;
      outNv_q    <= '0;
      outNx_q    <= '0;
    end else if (advance) begin
      stage_q    <= stage_d;
      tag_q      <= tag_d;
      vld_q      <= vld_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outTag_q   <= outTag_d;
      outNv_q    <= outNv_d;
      outNx_q    <= outNx_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_tag   = outTag_q;
  assign out_nv    = outNv_q;
  assign out_nx    = outNx_q;

endmodule

// File: tb/tb_sqrt_vec_pipe.sv
// Testbench for sqrt_vec_pipe (LANES=4, STAGES=4, TAG_W=8).
// It runs a directed vector table with hand-computed results, then streamed
// traffic checked against an fp16 square-root reference model built on
// real arithmetic, then a reset with transactions in flight.

module tb_sqrt_vec_pipe;

  localparam int LANES  = 4;
  localparam int STAGES = 4;
  localparam int TAG_W  = 8;

  logic                CLK = 1'b0;
  logic                nRST;
  logic                in_valid;
  logic                in_ready;
  logic [16*LANES-1:0] in_data;
  logic [LANES-1:0]    in_mask;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [16*LANES-1:0] out_data;
  logic [TAG_W-1:0]    out_tag;
  logic [LANES-1:0]    out_nv;
  logic [LANES-1:0]    out_nx;

  int asserts  = 0;
  int failures = 0;

  sqrt_vec_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_nv    (out_nv),
    .out_nx    (out_nx)
  );

  // 100 MHz-style free-running clock.
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] din;
    logic        act;
    logic [15:0] expData;
    logic        expNv;
    logic        expNx;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  tag;
    logic [3:0]  nv;
    logic [3:0]  nx;
  } txn_t;

  vec_t vecs [16];
  txn_t expQ [$];

  // Compare one value and count the comparison.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real p;
    p = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
    else        for (int i = 0; i < -k; i++) p = p / 2.0;
    return pow2_ret(p);
  endfunction

  function automatic real pow2_ret(input real p);
    return p;
  endfunction

  // Reference fp16 sqrt: exact value in double, correctly rounded to fp16.
  function automatic void refLane(input logic [15:0] x, input logic act,
                                  output logic [15:0] r, output logic nv, output logic nx);
    logic [4:0] e;
    logic [9:0] f;
    real        val, rt, sc, fr;
    int         ex, ip;
    e  = x[14:10];
    f  = x[9:0];
    r  = 16'h0000;
    nv = 1'b0;
    nx = 1'b0;
    if (!act) begin
      r = 16'h0000;
    end else if (e == 5'h1f && f != 10'd0) begin
      r  = 16'h7E00;
      nv = !f[9];
    end else if (e == 5'd0 && f == 10'd0) begin
      r = x;
    end else if (x[15]) begin
      r  = 16'h7E00;
      nv = 1'b1;
    end else if (e == 5'h1f) begin
      r = 16'h7C00;
    end else begin
      if (e == 5'd0) val = real'(int'(f)) * pow2(-24);
      else           val = real'(1024 + int'(f)) * pow2(int'(e) - 25);
      rt = $sqrt(val);
      ex = 0;
      while (rt >= 2.0) begin rt = rt / 2.0; ex++; end
      while (rt < 1.0)  begin rt = rt * 2.0; ex--; end
      sc = rt * 1024.0;
      ip = $rtoi(sc);
      fr = sc - real'(ip);
      nx = (fr != 0.0);
      if (fr > 0.5 || (fr == 0.5 && ip[0])) ip++;
      if (ip == 2048) begin ip = 1024; ex++; end
      r = {1'b0, 5'(ex + 15), 10'(ip - 1024)};
    end
  endfunction

  function automatic txn_t refTxn(input logic [63:0] d, input logic [3:0] m, input logic [7:0] tg);
    txn_t        t;
    logic [15:0] r;
    logic        nv, nx;
    t.tag = tg;
    t.data = '0;
    t.nv = '0;
    t.nx = '0;
    for (int l = 0; l < LANES; l++) begin
      refLane(d[16*l +: 16], m[l], r, nv, nx);
      t.data[16*l +: 16] = r;
      t.nv[l] = nv;
      t.nx[l] = nx;
    end
    return t;
  endfunction

  // Present one transaction at a negedge and hold it through one edge.
  task automatic applyStimulus(input logic [63:0] d, input logic [3:0] m, input logic [7:0] tg);
    in_data  = d;
    in_mask  = m;
    in_tag   = tg;
    in_valid = 1'b1;
    #1;
    checkOutput("acceptReady", in_ready, 1);
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid rises (bounded).
  task automatic waitOutput(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  // Streamed traffic with a scoreboard.
  // mode 0: back-to-back. mode 1: a 7-cycle stall mid-stream.
  // mode 2: every fp16 value on some lane, random valid and ready.
  // mode 3: random data and masks, random valid and ready.
  task automatic runStream(input int n, input int mode);
    int          sent, popped, guard, lastPop;
    logic        haveTx, prevStall;
    logic [63:0] d;
    logic [3:0]  m;
    logic [7:0]  tg;
    logic [79:0] prevOut;
    txn_t        e;
    sent = 0; popped = 0; guard = 0; lastPop = -1;
    haveTx = 1'b0; prevStall = 1'b0; prevOut = '0;
    d = '0; m = '0; tg = '0;
    while ((sent < n || expQ.size() > 0) && guard < n * 4 + 200) begin
      if (prevStall) checkOutput("stallHold", {out_data, out_tag, out_nv, out_nx}, prevOut);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(guard >= 8 && guard < 15);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (sent < n) begin
        if (!haveTx) begin
          tg = 8'(sent);
          case (mode)
            2: begin
              for (int l = 0; l < LANES; l++) d[16*l +: 16] = 16'(sent * 4 + l);
              m = 4'hF;
            end
            3: begin
              d = {$urandom, $urandom};
              m = 4'($urandom_range(0, 15));
            end
            default: begin
              d = {$urandom, $urandom};
              m = 4'hF;
            end
          endcase
          haveTx = 1'b1;
        end
        in_valid = (mode >= 2) ? ($urandom_range(0, 7) != 0) : 1'b1;
        in_data  = d;
        in_mask  = m;
        in_tag   = tg;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) checkOutput("stallInReady", in_ready, 0);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousOut", out_valid, 0);
        end else begin
          e = expQ.pop_front();
          popped++;
          checkOutput("stream", {out_data, out_tag, out_nv, out_nx}, {e.data, e.tag, e.nv, e.nx});
        end
        if (mode == 0 && lastPop >= 0) checkOutput("backToBack", guard, lastPop + 1);
        lastPop = guard;
      end
      if (in_valid && in_ready) begin
        expQ.push_back(refTxn(d, m, tg));
        sent++;
        haveTx = 1'b0;
      end
      prevStall = out_valid && !out_ready;
      prevOut   = {out_data, out_tag, out_nv, out_nx};
      @(negedge CLK);
      guard++;
    end
    checkOutput("streamCount", popped, n);
    expQ.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int lat;
    int ghost;

    vecs[0]  = '{16'h4000, 1'b1, 16'h3DA8, 1'b0, 1'b1};
    vecs[1]  = '{16'h5640, 1'b1, 16'h4900, 1'b0, 1'b0};
    vecs[2]  = '{16'h3400, 1'b1, 16'h3800, 1'b0, 1'b0};
    vecs[3]  = '{16'h0001, 1'b1, 16'h0C00, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 1'b1, 16'h8000, 1'b0, 1'b0};
    vecs[5]  = '{16'h7C00, 1'b1, 16'h7C00, 1'b0, 1'b0};
    vecs[6]  = '{16'hBC00, 1'b1, 16'h7E00, 1'b1, 1'b0};
    vecs[7]  = '{16'h7D00, 1'b1, 16'h7E00, 1'b1, 1'b0};
    vecs[8]  = '{16'h7E01, 1'b1, 16'h7E00, 1'b0, 1'b0};
    vecs[9]  = '{16'hFC00, 1'b1, 16'h7E00, 1'b1, 1'b0};
    vecs[10] = '{16'h8001, 1'b1, 16'h7E00, 1'b1, 1'b0};
    vecs[11] = '{16'h7BFF, 1'b1, 16'h5BFF, 1'b0, 1'b1};
    vecs[12] = '{16'h0400, 1'b1, 16'h2000, 1'b0, 1'b0};
    vecs[13] = '{16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{16'hFE00, 1'b1, 16'h7E00, 1'b0, 1'b0};

    nRST      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge CLK);
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstInReady", in_ready, 1);
    checkOutput("rstOutputs", {out_data, out_tag, out_nv, out_nx}, 0);
    nRST = 1'b1;
    @(negedge CLK);

    // Directed single-lane vectors; lanes 1..3 carry data but are masked.
    $display("[TB] directed vectors");
    for (int i = 0; i < 16; i++) begin
      applyStimulus({16'h4000, 16'h4000, 16'h4000, vecs[i].din}, {3'b000, vecs[i].act}, 8'(8'h40 + i));
      waitOutput(lat);
      checkOutput("latency", lat, STAGES + 1);
      checkOutput("vecData", out_data, {48'h0, vecs[i].expData});
      checkOutput("vecNv", out_nv, {3'b000, vecs[i].expNv});
      checkOutput("vecNx", out_nx, {3'b000, vecs[i].expNx});
      checkOutput("vecTag", out_tag, 8'h40 + i);
      @(negedge CLK);
      checkOutput("bubble", out_valid, 0);
    end

    $display("[TB] back-to-back stream");
    runStream(10, 0);
    $display("[TB] backpressure stream");
    runStream(20, 1);
    $display("[TB] exhaustive stream");
    runStream(16384, 2);
    $display("[TB] random mask stream");
    runStream(1500, 3);

    // Reset with three transactions in flight during a stall.
    $display("[TB] reset mid-stall");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data  = {16'h3400, 16'h3400, 16'h3400, 16'h3400};
      in_mask  = 4'hF;
      in_tag   = 8'(8'hA1 + i);
      in_valid = 1'b1;
      @(negedge CLK);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge CLK);
    checkOutput("preRstStall", {out_valid, in_ready}, 2'b10);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("midRstValid", out_valid, 0);
    checkOutput("midRstReady", in_ready, 1);
    checkOutput("midRstOutputs", {out_data, out_tag, out_nv, out_nx}, 0);
    @(negedge CLK);
    nRST      = 1'b1;
    out_ready = 1'b1;
    ghost = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (out_valid) ghost++;
    end
    checkOutput("ghostOut", ghost, 0);
    applyStimulus({48'h0, 16'h3400}, 4'h1, 8'h5B);
    waitOutput(lat);
    checkOutput("postRstLatency", lat, STAGES + 1);
    checkOutput("postRstData", {out_data, out_tag}, {48'h0, 16'h3800, 8'h5B});

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
